// File: rtl/beezip_sched_pkg.sv
// Shared types and helpers for the bitmap issue scheduler.
package beezip_sched_pkg;

    // Largest bitmap width the scheduler is built for.
    localparam int MAX_W = 64;

    // Scheduler FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_e;

    // Index width for a W-bit bitmap.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Binary encode a one-hot vector. OR-ing the set positions is enough
    // because at most one bit is set; an all-zero vector encodes to 0.
    function automatic logic [5:0] onehot_to_idx(input logic [MAX_W-1:0] onehot);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (onehot[i]) begin
                idx = idx | 6'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/priority_selector.sv
// Lowest-index-first one-hot selector: grants the least significant set bit.
module priority_selector #(
    parameter int W = 16
) (
    input  logic [W-1:0] input_vec,
    output logic [W-1:0] grant
);

    // Each bit wins only when no lower-index request is present.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_grant
            localparam logic [W-1:0] BELOW = (W'(1) << gi) - W'(1);
            assign grant[gi] = input_vec[gi] & ~(|(input_vec & BELOW));
        end
    endgenerate

endmodule

// File: rtl/bitmap_issue_scheduler.sv
// Serialises a request bitmap into a valid/ready stream of one-hot grants,
// lowest index first, tagged with the job id and marked on the last beat.
module bitmap_issue_scheduler
    import beezip_sched_pkg::*;
#(
    parameter  int W     = 16,
    parameter  int TAG_W = 8,
    localparam int IDX_W = idx_width(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_bitmap,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_onehot,
    output logic [IDX_W-1:0] out_idx,
    output logic [TAG_W-1:0] out_tag,
    output logic [IDX_W:0]   out_seq,
    output logic             out_last
);

    sched_state_e     state_reg, state_next;
    logic [W-1:0]     pending_reg, pending_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic [IDX_W:0]   seq_reg, seq_next;
    logic [W-1:0]     grant;
    logic             beat_last;
    logic             load_job;

    priority_selector #(.W(W)) u_priority_selector (
        .input_vec (pending_reg),
        .grant     (grant)
    );

    // The current grant is the final one when nothing else stays pending.
    // An empty job therefore yields a single all-zero last beat.
    assign beat_last = ((pending_reg & ~grant) == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Job context registers: remaining requests, tag and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            tag_reg     <= '0;
            seq_reg     <= '0;
        end else begin
            pending_reg <= pending_next;
            tag_reg     <= tag_next;
            seq_reg     <= seq_next;
        end
    end

    // Next-state and job context update; flush wins over any beat or reload.
    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        tag_next     = tag_reg;
        seq_next     = seq_reg;
        load_job     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    load_job   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_next   = IDLE;
                    pending_next = '0;
                end else if (out_ready) begin
                    if (!beat_last) begin
                        pending_next = pending_reg & ~grant;
                        seq_next     = seq_reg + 1'b1;
                    end else if (in_valid) begin
                        // Back-to-back job: reload while staying in ISSUE.
                        load_job = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (load_job) begin
            pending_next = in_bitmap;
            tag_next     = in_tag;
            seq_next     = '0;
        end
    end

    // Stream outputs from registered state; in_ready opens on the last beat.
    always_comb begin
        out_valid  = 1'b0;
        in_ready   = 1'b0;
        out_onehot = '0;
        out_idx    = '0;
        out_last   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
            end
            ISSUE: begin
                out_valid  = 1'b1;
                out_onehot = grant;
                out_idx    = IDX_W'(onehot_to_idx(MAX_W'(grant)));
                out_last   = beat_last;
                in_ready   = !flush && out_ready && beat_last;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign out_tag = tag_reg;
    assign out_seq = seq_reg;

endmodule

// File: tb/tb_bitmap_issue_scheduler.sv
// Self-checking bench for bitmap_issue_scheduler: directed scenarios plus
// randomised jobs checked against a per-job queue of expected beats.
module tb_bitmap_issue_scheduler;

    localparam int W     = 16;
    localparam int TAG_W = 8;
    localparam int IDX_W = 4;
    localparam int SEQ_W = IDX_W + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_bitmap = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_onehot;
    logic [IDX_W-1:0] out_idx;
    logic [TAG_W-1:0] out_tag;
    logic [SEQ_W-1:0] out_seq;
    logic             out_last;

    // One expected beat of the job in flight.
    typedef struct packed {
        logic [W-1:0]     onehot;
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [SEQ_W-1:0] seq;
        logic             last;
    } beat_t;

    beat_t        q[$];
    logic [W-1:0] job_bitmap = '0;
    logic [W-1:0] acc_or = '0;
    int           checks_total = 0;
    int           checks_passed = 0;
    int           rdy_mode = 0;      // 0: hold, 1: random, 2: 1,0,0,1 pattern
    bit           rand_flush = 1'b0;
    int           cyc_ctr = 0;
    int           t1_idx[4] = '{0, 5, 10, 15};
    logic [35:0]  rst_exp = {1'b0, 1'b1, 34'd0};

    bitmap_issue_scheduler #(.W(W), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bitmap  (in_bitmap),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_idx    (out_idx),
        .out_tag    (out_tag),
        .out_seq    (out_seq),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // Expected beats of a job: every set bit in ascending order, or one empty beat.
    task automatic load_job(input logic [W-1:0] bm, input logic [TAG_W-1:0] tg);
        int    k;
        int    n;
        beat_t b;
        k = $countones(bm);
        n = 0;
        job_bitmap = bm;
        acc_or = '0;
        if (k == 0) begin
            b = '0;
            b.tag = tg;
            b.last = 1'b1;
            q.push_back(b);
        end
        for (int i = 0; i < W; i++) begin
            if (bm[i]) begin
                b = '0;
                b.onehot[i] = 1'b1;
                b.idx = IDX_W'(i);
                b.tag = tg;
                b.seq = SEQ_W'(n);
                b.last = (n == k - 1);
                q.push_back(b);
                n++;
            end
        end
        $display("job   tag=%02h bitmap=%04h beats=%0d", tg, bm, q.size());
    endtask

    // One clock: entered at a negedge with inputs set, returns at the next negedge.
    task automatic cycle(input string name, output bit acc);
        bit    busy;
        bit    exp_rdy;
        beat_t b;
        if (rdy_mode == 1) out_ready = 1'($urandom_range(1));
        else if (rdy_mode == 2) out_ready = (cyc_ctr % 4 == 0) || (cyc_ctr % 4 == 3);
        if (rand_flush) flush = ($urandom_range(15) == 0);
        cyc_ctr++;
        #1;
        busy = (q.size() != 0);
        exp_rdy = 1'b1;
        if (busy) exp_rdy = !flush && out_ready && q[0].last;
        check({name, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
        check({name, ".out_valid"}, 64'(out_valid), 64'(busy));
        if (busy) begin
            check({name, ".beat"}, 64'({out_onehot, out_idx, out_tag, out_seq, out_last}), 64'(q[0]));
        end else begin
            check({name, ".idle_last"}, 64'(out_last), 64'd0);
        end
        acc = exp_rdy && in_valid;
        if (busy) begin
            if (flush) begin
                $display("flush tag=%02h dropped=%0d", q[0].tag, q.size());
                q.delete();
            end else if (out_ready) begin
                b = q.pop_front();
                acc_or = acc_or | out_onehot;
                $display("beat  tag=%02h seq=%0d idx=%0d last=%0b", out_tag, out_seq, out_idx, out_last);
                if (b.last) check({name, ".job_or"}, 64'(acc_or), 64'(job_bitmap));
            end
        end
        if (acc) load_job(in_bitmap, in_tag);
        @(negedge clk);
    endtask

    // Offer a job and clock until it is accepted (bounded).
    task automatic offer(input logic [W-1:0] bm, input logic [TAG_W-1:0] tg, input string name);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_bitmap = bm;
        in_tag = tg;
        while (!acc && n < 200) begin
            cycle(name, acc);
            n++;
        end
        check({name, ".accepted"}, 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    // Clock until the model has no beats left (bounded).
    task automatic drain(input string name);
        bit acc;
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            cycle(name, acc);
            n++;
        end
        check({name, ".drained"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        bit           acc;
        logic [W-1:0] bm;

        // Asynchronous reset values.
        #2 rst_n = 1'b0;
        #1;
        check("reset.outputs", 64'({out_valid, in_ready, out_onehot, out_idx, out_tag, out_seq, out_last}), 64'(rst_exp));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle("reset.idle", acc);

        // 0x8421: idx 0,5,10,15, tag on every beat, last only on 15.
        out_ready = 1'b1;
        offer(16'h8421, 8'h5A, "t1");
        for (int i = 0; i < 4; i++) begin
            check("t1.idx", 64'(out_idx), 64'(t1_idx[i]));
            check("t1.tag", 64'(out_tag), 64'h5A);
            cycle("t1", acc);
        end
        cycle("t1.after", acc);

        // Back-to-back 0x0003 then empty job, no bubble.
        offer(16'h0003, 8'h01, "t2a");
        offer(16'h0000, 8'h02, "t2b");
        check("t2.empty_onehot", 64'(out_onehot), 64'd0);
        check("t2.empty_tag", 64'(out_tag), 64'h02);
        drain("t2");
        cycle("t2.after", acc);

        // 0xFFFF with out_ready toggling 1,0,0,1.
        rdy_mode = 2;
        offer(16'hFFFF, 8'h03, "t3");
        drain("t3");
        rdy_mode = 0;
        out_ready = 1'b1;

        // 0x00F0 flushed on the second beat while stalled.
        offer(16'h00F0, 8'h04, "t4");
        cycle("t4.b0", acc);
        check("t4.second_idx", 64'(out_idx), 64'd5);
        out_ready = 1'b0;
        flush = 1'b1;
        cycle("t4.flush", acc);
        flush = 1'b0;
        out_ready = 1'b1;
        cycle("t4.idle", acc);
        offer(16'h0001, 8'h05, "t4n");
        drain("t4n");

        // Reset mid-job on 0x0700: outputs drop immediately, job not resumed.
        offer(16'h0700, 8'h06, "t5");
        cycle("t5.b0", acc);
        #2 rst_n = 1'b0;
        #1;
        check("t5.reset_outputs", 64'({out_valid, in_ready, out_onehot, out_idx, out_tag, out_seq, out_last}), 64'(rst_exp));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle("t5.idle", acc);
        cycle("t5.idle2", acc);

        // Randomised jobs, random backpressure and occasional flush.
        rdy_mode = 1;
        rand_flush = 1'b1;
        for (int j = 0; j < 60; j++) begin
            case ($urandom_range(3))
                0: bm = '0;
                1: bm = W'(1) << $urandom_range(W - 1);
                2: bm = W'($urandom);
                default: bm = W'($urandom & $urandom & $urandom);
            endcase
            offer(bm, TAG_W'(16 + j), "rnd");
        end
        rand_flush = 1'b0;
        flush = 1'b0;
        drain("rnd");
        cycle("rnd.after", acc);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
